irrigation_countdown_timer: RTL
===============================

Name: irrigation_countdown_timer

Overview:
- Receiver end of the timer preload interface: consumes per-bit setter/resetter preload lines for minutes tens, minutes units and seconds tens, plus the recount strobe.
- Holds the BCD MM:SS irrigation timer and counts it down once per 1 Hz tick.
- Signals expiry to the irrigation controller and drives the 7-segment display digit registers.

Parameters:
- AUTO_RELOAD, 0, when 1 an expiry reloads the last preload value and keeps running instead of stopping.
- MIN_D_MAX, 9, maximum legal value of the minutes tens digit.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- tick_1hz  input  1  one-clk-wide pulse per second
- recount  input  1  load strobe, qualifies all preload lines
- pause  input  1  level; while high, ticks are ignored
- minutes_d_setter  input  4  preload: bits forced to 1
- minutes_u_setter  input  4  preload: bits forced to 1
- minutes_d_resetter  input  4  preload: bits forced to 0
- minutes_u_resetter  input  4  preload: bits forced to 0
- seconds_d_resetter  input  4  preload: bits forced to 0
- minutes_d  output  4  BCD minutes tens
- minutes_u  output  4  BCD minutes units
- seconds_d  output  4  BCD seconds tens
- seconds_u  output  4  BCD seconds units
- running  output  1  high in RUNNING state
- expired  output  1  high in EXPIRED state
- done  output  1  one-clk pulse on expiry
- load_error  output  1  one-clk pulse on an illegal or conflicting preload

Behaviour:
- Reset (synchronous, highest priority): all digits 0, state IDLE; running, expired, done and load_error all 0.
- Priority each cycle: reset > recount > pause > tick_1hz.
- All outputs are registered.

Load (recount=1):
- Per bit, the loaded value is 1 if setter=1, 0 if resetter=1, otherwise the current bit.
- seconds_d has no setter, so it is reset-only. seconds_u has no preload lines and is cleared to 0.
- Setter and resetter both 1 on the same bit: the bit loads 0 (reset dominant) and load_error pulses.
- After merge, a digit above its maximum (minutes_d > MIN_D_MAX, minutes_u > 9, seconds_d > 5) is clamped to that maximum and load_error pulses.
- The loaded value is visible on the digit outputs the next cycle. It is also stored as the reload value used by AUTO_RELOAD.
- Next state is RUNNING, or EXPIRED if the loaded value is 00:00; the 00:00 case also pulses done.
- A tick in the same cycle as recount is dropped.
- recount in any state, including mid-run or PAUSED, reloads the timer.

States:
- IDLE: digits hold; ticks are ignored.
- RUNNING: on tick_1hz with pause=0, decrement MM:SS by one second (BCD borrow chain):
  - seconds_u 0 -> 9 with borrow
  - seconds_d 0 -> 5 with borrow
  - minutes_u 0 -> 9 with borrow
  - minutes_d decrements by one
  - If pause=1, go to PAUSED.
- PAUSED: digits hold and ticks are discarded (not queued). When pause=0, return to RUNNING the next cycle.
- EXPIRED: entered when a decrement produces 00:00. done pulses exactly one cycle, on entry.
  - AUTO_RELOAD=0: digits stay 00:00, ticks are ignored, and the timer stays here until recount or reset.
  - AUTO_RELOAD=1: EXPIRED lasts one cycle, then the reload value is loaded and the state returns to RUNNING.
- No decrement below 00:00 ever occurs (no wrap to 99:59).

Latency and sequencing:
- tick_1hz -> digits updated: 1 clk.
- Decrement 00:01 -> 00:00: the digits, expired=1 and done=1 all appear on the same edge.
- Ticks arriving on consecutive clks are each honoured. The bench must not rely on tick spacing.

Test Plan:
- Splinker preload: minutes_d_setter=0001, minutes_u_setter=0101, complementary resetters, recount for 1 clk -> 15:00 shown, running=1. One tick -> 14:59. Next tick -> 14:58.
- Dripper preload (30:00): tick -> 29:59. Run 1799 more ticks -> 00:00; done=1 for exactly one clk; expired=1; running=0. 5 further ticks -> still 00:00 and no done.
- Borrow chain: preload 10:00 -> tick gives 09:59. From 00:10, tick -> 00:09.
- Pause: running at 14:59, pause=1 for 10 ticks -> 14:59 held, state PAUSED. pause=0, then 1 tick -> 14:58.
- Recount at 07:23 while running -> 15:00 the next clk. Tick asserted in the same cycle as recount is dropped (display 15:00, not 14:59).
- Conflict and clamp: minutes_u_setter=minutes_u_resetter=0001 -> bit0 loads 0 and load_error pulses. Setter 1111 on minutes_u -> clamps to 9 and load_error pulses. Reset asserted mid-run -> 00:00, IDLE, all flags 0.

Source files
------------

// File: rtl/irrigation_countdown_timer.sv
// rtl/irrigation_countdown_timer.sv - BCD MM:SS irrigation countdown with bitwise set/reset preload
module irrigation_countdown_timer #(
    parameter int AUTO_RELOAD = 0,
    parameter int MIN_D_MAX   = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       recount,
    input  logic       pause,
    input  logic [3:0] minutes_d_setter,
    input  logic [3:0] minutes_u_setter,
    input  logic [3:0] minutes_d_resetter,
    input  logic [3:0] minutes_u_resetter,
    input  logic [3:0] seconds_d_resetter,
    output logic [3:0] minutes_d,
    output logic [3:0] minutes_u,
    output logic [3:0] seconds_d,
    output logic [3:0] seconds_u,
    output logic       running,
    output logic       expired,
    output logic       done,
    output logic       load_error
);

    typedef enum logic [1:0] {S_IDLE, S_RUNNING, S_PAUSED, S_EXPIRED} state_t;

    localparam logic [3:0] MD_MAX = 4'(MIN_D_MAX);

    state_t     r_state;
    logic [3:0] r_md, r_mu, r_sd, r_su;
    logic [3:0] r_rl_md, r_rl_mu, r_rl_sd;
    logic       r_running, r_expired, r_done, r_load_error;

    // Preload merge: resetter wins over setter, untouched bits keep the current digit.
    logic [3:0] w_md_m, w_mu_m, w_sd_m;
    logic [3:0] w_md_l, w_mu_l, w_sd_l;
    logic       w_conflict, w_clamped, w_load_zero, w_rl_zero;

    assign w_md_m = (r_md | minutes_d_setter) & ~minutes_d_resetter;
    assign w_mu_m = (r_mu | minutes_u_setter) & ~minutes_u_resetter;
    assign w_sd_m = r_sd & ~seconds_d_resetter;

    assign w_md_l = (w_md_m > MD_MAX) ? MD_MAX : w_md_m;
    assign w_mu_l = (w_mu_m > 4'd9)   ? 4'd9   : w_mu_m;
    assign w_sd_l = (w_sd_m > 4'd5)   ? 4'd5   : w_sd_m;

    assign w_conflict  = (|(minutes_d_setter & minutes_d_resetter)) |
                         (|(minutes_u_setter & minutes_u_resetter));
    assign w_clamped   = (w_md_m > MD_MAX) | (w_mu_m > 4'd9) | (w_sd_m > 4'd5);
    assign w_load_zero = (w_md_l == 4'd0) && (w_mu_l == 4'd0) && (w_sd_l == 4'd0);
    assign w_rl_zero   = (r_rl_md == 4'd0) && (r_rl_mu == 4'd0) && (r_rl_sd == 4'd0);

    // One-second BCD borrow chain.
    logic       w_b0, w_b1, w_b2, w_dec_zero;
    logic [3:0] w_su_dec, w_sd_dec, w_mu_dec, w_md_dec;

    assign w_b0     = (r_su == 4'd0);
    assign w_b1     = w_b0 && (r_sd == 4'd0);
    assign w_b2     = w_b1 && (r_mu == 4'd0);
    assign w_su_dec = w_b0 ? 4'd9 : r_su - 4'd1;
    assign w_sd_dec = w_b0 ? ((r_sd == 4'd0) ? 4'd5 : r_sd - 4'd1) : r_sd;
    assign w_mu_dec = w_b1 ? ((r_mu == 4'd0) ? 4'd9 : r_mu - 4'd1) : r_mu;
    assign w_md_dec = w_b2 ? r_md - 4'd1 : r_md;
    assign w_dec_zero = (w_md_dec == 4'd0) && (w_mu_dec == 4'd0) &&
                        (w_sd_dec == 4'd0) && (w_su_dec == 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_md         <= 4'd0;
            r_mu         <= 4'd0;
            r_sd         <= 4'd0;
            r_su         <= 4'd0;
            r_rl_md      <= 4'd0;
            r_rl_mu      <= 4'd0;
            r_rl_sd      <= 4'd0;
            r_running    <= 1'b0;
            r_expired    <= 1'b0;
            r_done       <= 1'b0;
            r_load_error <= 1'b0;
        end else begin
            r_done       <= 1'b0;
            r_load_error <= 1'b0;
            if (recount) begin
                r_md         <= w_md_l;
                r_mu         <= w_mu_l;
                r_sd         <= w_sd_l;
                r_su         <= 4'd0;
                r_rl_md      <= w_md_l;
                r_rl_mu      <= w_mu_l;
                r_rl_sd      <= w_sd_l;
                r_load_error <= w_conflict | w_clamped;
                if (w_load_zero) begin
                    r_state   <= S_EXPIRED;
                    r_running <= 1'b0;
                    r_expired <= 1'b1;
                    r_done    <= 1'b1;
                end else begin
                    r_state   <= S_RUNNING;
                    r_running <= 1'b1;
                    r_expired <= 1'b0;
                end
            end else begin
                case (r_state)
                    S_RUNNING: begin
                        if (pause) begin
                            r_state   <= S_PAUSED;
                            r_running <= 1'b0;
                        end else if (tick_1hz) begin
                            r_md <= w_md_dec;
                            r_mu <= w_mu_dec;
                            r_sd <= w_sd_dec;
                            r_su <= w_su_dec;
                            if (w_dec_zero) begin
                                r_state   <= S_EXPIRED;
                                r_running <= 1'b0;
                                r_expired <= 1'b1;
                                r_done    <= 1'b1;
                            end
                        end
                    end
                    S_PAUSED: begin
                        if (!pause) begin
                            r_state   <= S_RUNNING;
                            r_running <= 1'b1;
                        end
                    end
                    S_EXPIRED: begin
                        // A 00:00 reload value would re-expire forever, so it simply stays expired.
                        if ((AUTO_RELOAD != 0) && !w_rl_zero) begin
                            r_md      <= r_rl_md;
                            r_mu      <= r_rl_mu;
                            r_sd      <= r_rl_sd;
                            r_su      <= 4'd0;
                            r_state   <= S_RUNNING;
                            r_running <= 1'b1;
                            r_expired <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign minutes_d  = r_md;
    assign minutes_u  = r_mu;
    assign seconds_d  = r_sd;
    assign seconds_u  = r_su;
    assign running    = r_running;
    assign expired    = r_expired;
    assign done       = r_done;
    assign load_error = r_load_error;

endmodule
